// File: rtl/boid_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : boid_frame_sched
// Purpose  : Frame-level scheduler for the boid accelerator datapath.
//            On each frame tick it walks every boid i: reads i as the self
//            operand, streams every other boid j as a neighbour, sequences
//            the seven writeback stages and writes boid i back to memory.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous reset, active low
//   start      in   frame tick, accepted only when idle
//   hold       in   memory-owner hold, honoured only at boid boundaries
//   rd_en      out  boid memory read strobe
//   rd_addr    out  boid memory read address
//   r_en_tot   out  datapath: latch self boid (data present this cycle)
//   r_en_itr   out  datapath: accumulate neighbour (data present this cycle)
//   wb_en      out  one-hot writeback stage strobes
//   mem_we     out  boid memory write strobe
//   wr_addr    out  boid memory write address
//   cur_boid   out  index of the boid being processed (0 when idle)
//   busy       out  frame in progress
//   done       out  one-cycle pulse when a frame completes
//   frame_cnt  out  completed-frame counter (wraps)
// ============================================================================
module boid_frame_sched #(
    parameter int N_BOIDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        hold,
    output logic        rd_en,
    output logic [5:0]  rd_addr,
    output logic        r_en_tot,
    output logic        r_en_itr,
    output logic [6:0]  wb_en,
    output logic        mem_we,
    output logic [5:0]  wr_addr,
    output logic [5:0]  cur_boid,
    output logic        busy,
    output logic        done,
    output logic [15:0] frame_cnt
);

    localparam logic [5:0] LAST_IDX = 6'(N_BOIDS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // The state register holds the state of the cycle currently visible on
    // the outputs; every output register is loaded with the value it must
    // show in the following cycle.
    state_t      state_q, state_d;
    logic [5:0]  i_q, i_d;
    logic [5:0]  j_q, j_d;
    logic [2:0]  k_q, k_d;
    logic        rd_en_q, rd_en_d;
    logic [5:0]  rd_addr_q, rd_addr_d;
    logic        r_en_tot_q, r_en_tot_d;
    logic        r_en_itr_q, r_en_itr_d;
    logic [6:0]  wb_en_q, wb_en_d;
    logic        mem_we_q, mem_we_d;
    logic [5:0]  wr_addr_q, wr_addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Neighbour walk helpers: the self index is skipped combinationally so
    // each boid spends exactly N_BOIDS-1 cycles issuing neighbour reads.
    logic [5:0] first_nb;
    logic [5:0] last_nb;
    logic [5:0] j_plus1;
    logic [5:0] next_nb;
    logic [5:0] i_plus1;

    assign first_nb = (i_q == 6'd0) ? 6'd1 : 6'd0;
    assign last_nb  = (i_q == LAST_IDX) ? (LAST_IDX - 6'd1) : LAST_IDX;
    assign j_plus1  = j_q + 6'd1;
    assign next_nb  = (j_plus1 == i_q) ? (j_q + 6'd2) : j_plus1;
    assign i_plus1  = i_q + 6'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            i_q         <= 6'd0;
            j_q         <= 6'd0;
            k_q         <= 3'd0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= 6'd0;
            r_en_tot_q  <= 1'b0;
            r_en_itr_q  <= 1'b0;
            wb_en_q     <= 7'd0;
            mem_we_q    <= 1'b0;
            wr_addr_q   <= 6'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            r_en_tot_q  <= r_en_tot_d;
            r_en_itr_q  <= r_en_itr_d;
            wb_en_q     <= wb_en_d;
            mem_we_q    <= mem_we_d;
            wr_addr_q   <= wr_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        r_en_tot_d  = 1'b0;
        r_en_itr_d  = 1'b0;
        wb_en_d     = 7'd0;
        mem_we_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    i_d     = 6'd0;
                    busy_d  = 1'b1;
                    if (!hold) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = 6'd0;
                    end
                end
            end

            // A LOAD cycle either carries the self read (rd_en_q set) or is
            // a hold stall, in which case hold is re-sampled for next cycle.
            S_LOAD: begin
                if (rd_en_q) begin
                    state_d    = S_ITER;
                    j_d        = first_nb;
                    rd_en_d    = 1'b1;
                    rd_addr_d  = first_nb;
                    r_en_tot_d = 1'b1;
                end else if (!hold) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = i_q;
                end
            end

            // Each neighbour read returns one cycle later, hence r_en_itr is
            // raised for the cycle after every ITER cycle, including the
            // first WB cycle.
            S_ITER: begin
                r_en_itr_d = 1'b1;
                if (j_q == last_nb) begin
                    state_d = S_WB;
                    k_d     = 3'd0;
                    wb_en_d = 7'd1;
                end else begin
                    j_d       = next_nb;
                    rd_en_d   = 1'b1;
                    rd_addr_d = next_nb;
                end
            end

            S_WB: begin
                if (k_q != 3'd6) begin
                    k_d     = k_q + 3'd1;
                    wb_en_d = 7'd1 << k_d;
                    if (k_q == 3'd5) begin
                        mem_we_d  = 1'b1;
                        wr_addr_d = i_q;
                    end
                end else if (i_q == LAST_IDX) begin
                    state_d     = S_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else begin
                    state_d = S_LOAD;
                    i_d     = i_plus1;
                    if (!hold) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = i_plus1;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                i_d     = 6'd0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign r_en_tot  = r_en_tot_q;
    assign r_en_itr  = r_en_itr_q;
    assign wb_en     = wb_en_q;
    assign mem_we    = mem_we_q;
    assign wr_addr   = wr_addr_q;
    assign cur_boid  = i_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire
